// File: rtl/puf_ctrl_pkg.sv
// puf_ctrl_pkg: shared FSM state type, reset challenge and vote threshold for the DAPUF sequencer
// Contents:
//   state_e      - sequencer states IDLE/PRE/EVAL/DONE
//   CHAL_DEFAULT - challenge bus value after reset
//   vote_thr()   - majority threshold; a bit wins when its vote count exceeds this
package puf_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_e;

    localparam logic [39:0] CHAL_DEFAULT = 40'hFF_FFFF_FFFF;

    function automatic int vote_thr(input int num_eval);
        return num_eval / 2;
    endfunction

endpackage

// File: rtl/puf_vote_bank.sv
// puf_vote_bank: RESP_W parallel vote counters with clear, sample enable and majority output
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   clr_i        - zero all counters (wins over sample_i)
//   sample_i     - add resp_i into the counters this cycle
//   resp_i       - raw response bits
//   maj_o        - majority of the counts as they will be after this edge
//   unst_o       - (PUF_UNSTABLE_MASK_EN only) count neither 0 nor NUM_EVAL after this edge
module puf_vote_bank
    import puf_ctrl_pkg::*;
#(
    parameter int RESP_W   = 40,
    parameter int NUM_EVAL = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              sample_i,
    input  logic [RESP_W-1:0] resp_i,
`ifdef PUF_UNSTABLE_MASK_EN
    output logic [RESP_W-1:0] maj_o,
    output logic [RESP_W-1:0] unst_o
`else
    output logic [RESP_W-1:0] maj_o
`endif
);

    localparam int CW = $clog2(NUM_EVAL + 1);
    localparam logic [CW-1:0] THR = CW'(vote_thr(NUM_EVAL));

    logic [CW-1:0] cnt_q [RESP_W];
    logic [CW-1:0] cnt_d [RESP_W];

    // Outputs look at the next-state counts so the controller can register
    // the final verdict on the same edge that takes the last sample.
    always_comb begin
        for (int i = 0; i < RESP_W; i++) begin
            cnt_d[i] = clr_i ? '0 : cnt_q[i] + CW'(sample_i & resp_i[i]);
            maj_o[i] = cnt_d[i] > THR;
        end
    end

`ifdef PUF_UNSTABLE_MASK_EN
    localparam logic [CW-1:0] ALL = CW'(NUM_EVAL);

    always_comb begin
        for (int i = 0; i < RESP_W; i++) begin
            unst_o[i] = (cnt_d[i] != '0) && (cnt_d[i] != ALL);
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < RESP_W; i++) begin
            cnt_q[i] <= rst_i ? '0 : cnt_d[i];
        end
    end

endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: DAPUF precharge/evaluate sequencer with NUM_EVAL-way majority voting
// Ports:
//   Clk, RST      - clock, synchronous active-high reset
//   start         - request pulse, accepted only in IDLE
//   challenge_in  - challenge sampled on the accepted start
//   resp_in       - raw DAPUF outputs
//   challenge_o   - challenge bus to the array (all ones after reset)
//   excite_l/_r   - excite lines, high except during EVAL
//   busy          - high in PRE, EVAL and DONE
//   done          - one-cycle pulse, response_out valid from this cycle
//   response_out  - majority-voted response, held until next done or reset
//   unstable_mask - (PUF_UNSTABLE_MASK_EN only) bits that disagreed across evaluations
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int CHAL_W   = 40,
    parameter int RESP_W   = 40,
    parameter int PRE_CYC  = 2,
    parameter int EVAL_CYC = 19,
    parameter int NUM_EVAL = 5
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge_in,
    input  logic [RESP_W-1:0] resp_in,
    output logic [CHAL_W-1:0] challenge_o,
    output logic              excite_l,
    output logic              excite_r,
    output logic              busy,
    output logic              done,
`ifdef PUF_UNSTABLE_MASK_EN
    output logic [RESP_W-1:0] response_out,
    output logic [RESP_W-1:0] unstable_mask
`else
    output logic [RESP_W-1:0] response_out
`endif
);

    if (NUM_EVAL < 1 || (NUM_EVAL % 2) == 0) begin : g_bad_num_eval
        $error("puf_eval_ctrl: NUM_EVAL must be odd and at least 1");
    end
    if (PRE_CYC < 1 || EVAL_CYC < 1) begin : g_bad_cyc
        $error("puf_eval_ctrl: PRE_CYC and EVAL_CYC must be at least 1");
    end

    localparam int PW = $clog2((PRE_CYC > EVAL_CYC ? PRE_CYC : EVAL_CYC) + 1);
    localparam int EW = $clog2(NUM_EVAL + 1);

    state_e            state_q;
    logic [PW-1:0]     phase_q;
    logic [EW-1:0]     eval_q;
    logic [CHAL_W-1:0] chal_q;
    logic              excite_q;
    logic              busy_q;
    logic              done_q;
    logic [RESP_W-1:0] resp_q;
    logic [RESP_W-1:0] maj;
    logic              accept;
    logic              sample;
    logic              pre_last;
    logic              eval_last;

    assign accept    = (state_q == IDLE) && start;
    assign pre_last  = phase_q == PW'(PRE_CYC - 1);
    assign eval_last = phase_q == PW'(EVAL_CYC - 1);
    assign sample    = (state_q == EVAL) && eval_last;

`ifdef PUF_UNSTABLE_MASK_EN
    logic [RESP_W-1:0] unst;
    logic [RESP_W-1:0] unst_q;

    puf_vote_bank #(.RESP_W(RESP_W), .NUM_EVAL(NUM_EVAL)) u_votes (
        .clk_i(Clk), .rst_i(RST), .clr_i(accept), .sample_i(sample),
        .resp_i(resp_in), .maj_o(maj), .unst_o(unst)
    );

    always_ff @(posedge Clk) begin
        unst_q <= RST ? '0 : (sample && eval_q == EW'(NUM_EVAL - 1)) ? unst : unst_q;
    end

    assign unstable_mask = unst_q;
`else
    puf_vote_bank #(.RESP_W(RESP_W), .NUM_EVAL(NUM_EVAL)) u_votes (
        .clk_i(Clk), .rst_i(RST), .clr_i(accept), .sample_i(sample),
        .resp_i(resp_in), .maj_o(maj)
    );
`endif

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            eval_q   <= '0;
            chal_q   <= CHAL_W'(CHAL_DEFAULT);
            excite_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            resp_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= PRE;
                        chal_q  <= challenge_in;
                        phase_q <= '0;
                        eval_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                PRE: begin
                    phase_q <= pre_last ? '0 : phase_q + 1'b1;
                    if (pre_last) begin
                        state_q  <= EVAL;
                        excite_q <= 1'b0;
                    end
                end
                EVAL: begin
                    phase_q <= eval_last ? '0 : phase_q + 1'b1;
                    if (eval_last) begin
                        excite_q <= 1'b1;
                        eval_q   <= eval_q + 1'b1;
                        // maj already includes this evaluation's sample
                        if (eval_q == EW'(NUM_EVAL - 1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            resp_q  <= maj;
                        end else begin
                            state_q <= PRE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign challenge_o  = chal_q;
    assign excite_l     = excite_q;
    assign excite_r     = excite_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign response_out = resp_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: self-checking bench for puf_eval_ctrl (PRE_CYC=2, EVAL_CYC=4, NUM_EVAL=3 and a NUM_EVAL=1 copy)
module tb_puf_eval_ctrl;

    localparam int P = 2;
    localparam int E = 4;
    localparam int N = 3;
    localparam logic [39:0] ONES = 40'hFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, start, start1;
    logic [39:0] chal_in, resp_in, chal1, resp1;
    logic [39:0] chal_o, resp_out, chal1_o, resp1_out;
    logic        exl, exr, busy, done, exl1, exr1, busy1, done1;
`ifdef PUF_UNSTABLE_MASK_EN
    logic [39:0] unst, unst1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    puf_eval_ctrl #(.CHAL_W(40), .RESP_W(40), .PRE_CYC(P), .EVAL_CYC(E), .NUM_EVAL(N)) u0 (
        .Clk(clk), .RST(rst), .start(start), .challenge_in(chal_in), .resp_in(resp_in),
        .challenge_o(chal_o), .excite_l(exl), .excite_r(exr), .busy(busy), .done(done),
`ifdef PUF_UNSTABLE_MASK_EN
        .response_out(resp_out), .unstable_mask(unst)
`else
        .response_out(resp_out)
`endif
    );

    puf_eval_ctrl #(.CHAL_W(40), .RESP_W(40), .PRE_CYC(P), .EVAL_CYC(E), .NUM_EVAL(1)) u1 (
        .Clk(clk), .RST(rst), .start(start1), .challenge_in(chal1), .resp_in(resp1),
        .challenge_o(chal1_o), .excite_l(exl1), .excite_r(exr1), .busy(busy1), .done(done1),
`ifdef PUF_UNSTABLE_MASK_EN
        .response_out(resp1_out), .unstable_mask(unst1)
`else
        .response_out(resp1_out)
`endif
    );

    typedef struct {
        logic [39:0] chal;
        logic [39:0] r0, r1, r2;
        logic [39:0] exp_r;
        logic [39:0] exp_u;
        bit          poke;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Reference: count the ones each bit saw, majority wins, any disagreement is unstable.
    function automatic void model(input logic [39:0] r0, r1, r2, output logic [39:0] m, u);
        for (int i = 0; i < 40; i++) begin
            int n;
            n = int'(r0[i]) + int'(r1[i]) + int'(r2[i]);
            m[i] = 2 * n > N;
            u[i] = n != 0 && n != N;
        end
    endfunction

    task automatic transact(input string nm, input logic [39:0] ch, r0, r1, r2,
                            input logic [39:0] exp_r, exp_u, input bit poke);
        logic [39:0] rr [3];
        int lat, bad;
        rr = '{r0, r1, r2};
        lat = -1;
        bad = 0;
        @(negedge clk);
        start = 1'b1;
        chal_in = ch;
        resp_in = r0;
        @(posedge clk);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0;
                check({nm, "_chal_latched"}, 64'(chal_o), 64'(ch));
            end
            if (done) begin
                lat = j + 1;
                break;
            end
            if (j < N * (P + E) && (exl !== ((j % (P + E)) < P) || exr !== exl || busy !== 1'b1)) bad++;
            if (j % (P + E) == 0 && j / (P + E) < N) resp_in = rr[j / (P + E)];
            if (poke && j == 7) begin
                start = 1'b1;
                chal_in = 40'hA5A5FFFFFF;
            end
            if (poke && j == 8) start = 1'b0;
            @(posedge clk);
        end
        check({nm, "_excite_pattern"}, 64'(bad), 64'd0);
        check({nm, "_latency"}, 64'(lat), 64'd19);
        check({nm, "_response"}, 64'(resp_out), 64'(exp_r));
`ifdef PUF_UNSTABLE_MASK_EN
        check({nm, "_unstable"}, 64'(unst), 64'(exp_u));
`endif
        @(negedge clk);
        check({nm, "_done_one_cycle"}, 64'({done, busy}), 64'd0);
        check({nm, "_chal_held"}, 64'(chal_o), 64'(ch));
    endtask

    task automatic transact1(input string nm, input logic [39:0] ch, r);
        int lat;
        lat = -1;
        @(negedge clk);
        start1 = 1'b1;
        chal1 = ch;
        resp1 = r;
        @(posedge clk);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start1 = 1'b0;
                check({nm, "_chal_latched"}, 64'(chal1_o), 64'(ch));
            end
            if (done1) begin
                lat = j + 1;
                break;
            end
            @(posedge clk);
        end
        check({nm, "_latency"}, 64'(lat), 64'd7);
        check({nm, "_response"}, 64'(resp1_out), 64'(r));
`ifdef PUF_UNSTABLE_MASK_EN
        check({nm, "_unstable"}, 64'(unst1), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int nd, first, second;
        logic [39:0] a, b, c, m, u, k;
        vecs[0] = '{40'h5A5A5A5A5A, 40'h0123456789, 40'h0123456789, 40'h0123456789,
                    40'h0123456789, 40'h0000000000, 1'b0};
        vecs[1] = '{40'h3C3C3C3C3C, 40'hFF00000000, 40'hFF000000FF, 40'h00000000FF,
                    40'hFF000000FF, 40'hFF000000FF, 1'b0};
        vecs[2] = '{40'h0F1E2D3C4B, 40'hAAAAAAAAAA, 40'h5555555555, 40'hFFFFFFFFFF,
                    40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 1'b1};
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        chal_in = '0;
        resp_in = '0;
        chal1 = '0;
        resp1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_excite", 64'({exl, exr}), 64'd3);
        check("rst_chal", 64'(chal_o), 64'(ONES));
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_response", 64'(resp_out), 64'd0);
`ifdef PUF_UNSTABLE_MASK_EN
        check("rst_unstable", 64'(unst), 64'd0);
`endif
        rst = 1'b0;

        for (int v = 0; v < 3; v++)
            transact($sformatf("vec%0d", v), vecs[v].chal, vecs[v].r0, vecs[v].r1, vecs[v].r2,
                     vecs[v].exp_r, vecs[v].exp_u, vecs[v].poke);
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("busy_start_ignored_no_extra_done", 64'(nd), 64'd0);

        for (int t = 0; t < 12; t++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = {$urandom, $urandom};
            model(a, b, c, m, u);
            transact($sformatf("rnd%0d", t), {$urandom, $urandom}, a, b, c, m, u, 1'b0);
        end

        @(negedge clk);
        start = 1'b1;
        chal_in = 40'h0F0F0F0F0F;
        resp_in = ONES;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mid_second_eval_excite", 64'({exl, busy}), 64'b01);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_excite", 64'({exl, exr}), 64'd3);
        check("mid_rst_chal", 64'(chal_o), 64'(ONES));
        check("mid_rst_busy_done", 64'({busy, done}), 64'd0);
        check("mid_rst_response", 64'(resp_out), 64'd0);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("mid_rst_no_done", 64'(nd), 64'd0);
        check("mid_rst_response_kept", 64'(resp_out), 64'd0);

        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        chal_in = 40'h1234512345;
        @(posedge clk);
        @(negedge clk);
        check("rst_start_busy", 64'(busy), 64'd0);
        check("rst_start_chal", 64'(chal_o), 64'(ONES));
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_start_still_idle", 64'(busy), 64'd0);

        k = 40'h13579BDF02;
        start = 1'b1;
        chal_in = 40'h2468ACE013;
        resp_in = k;
        nd = 0;
        first = -1;
        second = -1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                nd++;
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 64'(nd), 64'd2);
        check("b2b_done_gap", 64'(second - first), 64'd20);
        check("b2b_response", 64'(resp_out), 64'(k));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        transact1("ne1_fixed", 40'h1111122222, 40'hDEADBEEF00);
        for (int t = 0; t < 3; t++)
            transact1($sformatf("ne1_rnd%0d", t), {$urandom, $urandom}, {$urandom, $urandom});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
